// File: rtl/card_shoe.sv
// Multi-deck card shoe: per-rank inventory, LFSR-driven rank selection with
// linear probing past exhausted ranks, and a 13-cycle rank-by-rank refill.
module card_shoe #(
  parameter int          NUM_DECKS  = 1,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          LOW_THRESH = 13,
  localparam int         CW         = $clog2(52*NUM_DECKS+1),
  localparam int         RW         = $clog2(4*NUM_DECKS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          draw_req,
  input  logic          shuffle_req,
  output logic          card_valid,
  output logic [3:0]    card,
  output logic [3:0]    card_points,
  output logic [CW-1:0] cards_left,
  output logic          empty,
  output logic          low,
  output logic          busy,
  output logic          draw_err
);

  typedef enum logic [1:0] {IDLE, SEARCH, SHUFFLE} state_t;

  localparam logic [15:0]   SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]   LFSR_MASK = 16'hB400;
  localparam logic [RW-1:0] RANK_FULL = RW'(4*NUM_DECKS);
  localparam logic [CW-1:0] SHOE_FULL = CW'(52*NUM_DECKS);
  localparam logic [31:0]   LOW_T     = 32'(LOW_THRESH);
  localparam logic [3:0]    LAST_IDX  = 4'd12;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    probe_q, probe_d;
  logic [3:0]    fill_q, fill_d;
  logic [3:0]    card_q, card_d;
  logic [3:0]    points_q, points_d;
  logic [CW-1:0] cards_left_q, cards_left_d;
  logic          card_valid_q, card_valid_d;
  logic          draw_err_q, draw_err_d;
  logic [RW-1:0] rank_cnt_q [13];
  logic [RW-1:0] rank_cnt_d [13];
  logic [12:0]   rank_avail;
  logic [3:0]    start_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 13; gi++) begin : g_avail
      assign rank_avail[gi] = |rank_cnt_q[gi];
    end
  endgenerate

  // Fold the 4-bit LFSR slice onto 0..12 so every rank can be a starting point.
  assign start_idx = (lfsr_q[3:0] >= 4'd13) ? (lfsr_q[3:0] - 4'd13) : lfsr_q[3:0];

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    probe_d      = probe_q;
    fill_d       = fill_q;
    card_d       = card_q;
    points_d     = points_q;
    cards_left_d = cards_left_q;
    card_valid_d = 1'b0;
    draw_err_d   = 1'b0;
    rank_cnt_d   = rank_cnt_q;

    case (state_q)
      IDLE: begin
        if (shuffle_req) begin
          state_d = SHUFFLE;
          fill_d  = 4'd0;
        end else if (draw_req) begin
          if (cards_left_q == '0) begin
            draw_err_d = 1'b1;
          end else begin
            probe_d = start_idx;
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (rank_avail[probe_q]) begin
          rank_cnt_d[probe_q] = rank_cnt_q[probe_q] - RW'(1);
          cards_left_d        = cards_left_q - CW'(1);
          card_d              = probe_q + 4'd1;
          points_d            = (probe_q >= 4'd9) ? 4'd10 : (probe_q + 4'd1);
          card_valid_d        = 1'b1;
          state_d             = IDLE;
        end else begin
          probe_d = (probe_q == LAST_IDX) ? 4'd0 : (probe_q + 4'd1);
        end
      end
      SHUFFLE: begin
        rank_cnt_d[fill_q] = RANK_FULL;
        if (fill_q == LAST_IDX) begin
          cards_left_d = SHOE_FULL;
          state_d      = IDLE;
        end else begin
          fill_d = fill_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED_EFF;
      probe_q      <= 4'd0;
      fill_q       <= 4'd0;
      card_q       <= 4'd0;
      points_q     <= 4'd0;
      cards_left_q <= SHOE_FULL;
      card_valid_q <= 1'b0;
      draw_err_q   <= 1'b0;
      for (int i = 0; i < 13; i++) begin
        rank_cnt_q[i] <= RANK_FULL;
      end
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      probe_q      <= probe_d;
      fill_q       <= fill_d;
      card_q       <= card_d;
      points_q     <= points_d;
      cards_left_q <= cards_left_d;
      card_valid_q <= card_valid_d;
      draw_err_q   <= draw_err_d;
      rank_cnt_q   <= rank_cnt_d;
    end
  end

  assign card_valid  = card_valid_q;
  assign card        = card_q;
  assign card_points = points_q;
  assign cards_left  = cards_left_q;
  assign draw_err    = draw_err_q;
  assign busy        = (state_q != IDLE);
  assign empty       = (cards_left_q == '0);
  assign low         = 32'(cards_left_q) < LOW_T;

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboarded random-draw bench: a one-deck and a two-deck shoe share the
// request inputs; only the selected one is out of reset and observed.
module tb_card_shoe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r1 = 1'b1, r2 = 1'b1;
  logic draw_req = 1'b0, shuffle_req = 1'b0;

  logic       v1, e1, l1, b1, de1;
  logic [3:0] c1, p1;
  logic [5:0] cl1;
  logic       v2, e2, l2, b2, de2;
  logic [3:0] c2, p2;
  logic [6:0] cl2;

  card_shoe #(.NUM_DECKS(1)) dut1 (
    .clk(clk), .reset(r1), .draw_req(draw_req), .shuffle_req(shuffle_req),
    .card_valid(v1), .card(c1), .card_points(p1), .cards_left(cl1),
    .empty(e1), .low(l1), .busy(b1), .draw_err(de1));

  card_shoe #(.NUM_DECKS(2)) dut2 (
    .clk(clk), .reset(r2), .draw_req(draw_req), .shuffle_req(shuffle_req),
    .card_valid(v2), .card(c2), .card_points(p2), .cards_left(cl2),
    .empty(e2), .low(l2), .busy(b2), .draw_err(de2));

  bit sel = 1'b0;
  logic m_valid, m_empty, m_low, m_busy, m_err, r_act;
  int   m_card, m_pts, m_cl;

  always_comb begin
    m_valid = sel ? v2  : v1;
    m_empty = sel ? e2  : e1;
    m_low   = sel ? l2  : l1;
    m_busy  = sel ? b2  : b1;
    m_err   = sel ? de2 : de1;
    m_card  = sel ? int'(c2)  : int'(c1);
    m_pts   = sel ? int'(p2)  : int'(p1);
    m_cl    = sel ? int'(cl2) : int'(cl1);
    r_act   = sel ? r2 : r1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference LFSR: Galois form built from the polynomial's exponent list.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int taps [4] = '{16, 14, 13, 11};
    logic [15:0] mask = '0;
    for (int k = 0; k < 4; k++) mask[taps[k]-1] = 1'b1;
    return l[0] ? ((l >> 1) ^ mask) : (l >> 1);
  endfunction

  int          cyc = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= r_act ? 16'hACE1 : lfsr_next(lfsr_m);
  end

  int inv [13];
  int total;
  int nd;
  int seen [14];

  typedef struct {
    bit err;
    int card;
    int samp;
    int cyc;
  } exp_t;
  exp_t q[$];

  // Monitor: every pulse from the observed shoe must match the oldest expectation.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (!r_act && (m_valid || m_err)) begin
        if (q.size() == 0) begin
          chk("spurious_pulse", int'(m_valid) + 2*int'(m_err), 0);
        end else begin
          e = q.pop_front();
          chk("pulse_is_err", int'(m_err), int'(e.err));
          chk("pulse_cycle", cyc, e.cyc);
          if (!e.err) begin
            chk("card", m_card, e.card);
            chk("card_points", m_pts, (e.card < 10) ? e.card : 10);
            lat = cyc - e.samp + 1;
            chk("latency_in_2_14", int'(lat >= 2 && lat <= 14), 1);
            if (m_card >= 1 && m_card <= 13) seen[m_card]++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic void predict(input logic [15:0] l, output int rank, output int n);
    int p = int'(l[3:0]) % 13;
    rank = 0;
    n    = 0;
    for (int k = 1; k <= 13; k++) begin
      if (inv[p] > 0) begin
        rank = p + 1;
        n    = k;
        return;
      end
      p = (p + 1) % 13;
    end
  endfunction

  function automatic int peek(input int i);
    return sel ? int'(dut2.rank_cnt_q[i]) : int'(dut1.rank_cnt_q[i]);
  endfunction

  task automatic model_full();
    for (int r = 0; r < 13; r++) inv[r] = 4 * nd;
    total = 52 * nd;
  endtask

  task automatic clear_seen();
    for (int r = 0; r < 14; r++) seen[r] = 0;
  endtask

  task automatic check_level();
    chk("cards_left", m_cl, total);
    chk("empty", int'(m_empty), int'(total == 0));
    chk("low", int'(m_low), int'(total < 13));
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40; t++) begin
      if (!m_busy) break;
      tick();
    end
    chk("busy_wait", int'(m_busy), 0);
  endtask

  task automatic reset_check();
    chk("rst_cards_left", m_cl, 52 * nd);
    chk("rst_empty", int'(m_empty), 0);
    chk("rst_low", int'(m_low), 0);
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_card", m_card, 0);
    chk("rst_points", m_pts, 0);
    chk("rst_valid", int'(m_valid), 0);
    for (int i = 0; i < 13; i++) chk("rst_rank_cnt", peek(i), 4 * nd);
  endtask

  task automatic draw_once();
    int rank, n, k;
    wait_idle();
    k = cyc;
    if (total == 0) begin
      q.push_back('{err: 1'b1, card: 0, samp: k + 1, cyc: k + 1});
    end else begin
      predict(lfsr_m, rank, n);
      inv[rank-1]--;
      total--;
      q.push_back('{err: 1'b0, card: rank, samp: k + 1, cyc: k + 1 + n});
    end
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("pulse_timeout", q.size(), 0);
    q.delete();
    tick();
    check_level();
  endtask

  task automatic do_shuffle(input bit with_draw);
    int bc = 0;
    wait_idle();
    shuffle_req = 1'b1;
    draw_req    = with_draw;
    tick();
    shuffle_req = 1'b0;
    draw_req    = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (!m_busy) break;
      bc++;
      if (t == 2) draw_req = 1'b1;
      if (t == 3) draw_req = 1'b0;
      tick();
    end
    draw_req = 1'b0;
    chk("shuffle_busy_cycles", bc, 13);
    model_full();
    check_level();
  endtask

  initial begin
    int  rank, n;
    bit  found;

    // One-deck shoe.
    nd = 1;
    clear_seen();
    repeat (3) tick();
    r1 = 1'b0;
    tick();
    model_full();
    reset_check();

    repeat (52) draw_once();
    for (int r = 1; r <= 13; r++) chk("rank_seen_x4", seen[r], 4);
    draw_once();
    do_shuffle(1'b0);
    repeat (12) draw_once();
    do_shuffle(1'b1);

    // Two-deck shoe, starting with a reset that lands in the middle of a search.
    r1  = 1'b1;
    sel = 1'b1;
    tick();
    tick();
    r2 = 1'b0;
    nd = 2;
    model_full();
    clear_seen();
    tick();
    reset_check();

    found = 1'b0;
    for (int i = 0; i < 110 && !found; i++) begin
      if (total == 0) break;
      wait_idle();
      predict(lfsr_m, rank, n);
      if (n >= 3) begin
        found    = 1'b1;
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        tick();
        tick();
        r2 = 1'b1;
        tick();
        r2 = 1'b0;
      end else begin
        draw_once();
      end
    end
    if (!found) begin
      r2 = 1'b1;
      tick();
      r2 = 1'b0;
    end
    tick();
    model_full();
    clear_seen();
    reset_check();

    repeat (104) draw_once();
    for (int r = 1; r <= 13; r++) chk("rank_seen_x8", seen[r], 8);
    draw_once();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
